// File: rtl/store_serializer_pkg.sv
// rtl/store_serializer_pkg.sv - size encodings and FSM state type for the store serializer
package store_serializer_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/store_serializer_if.sv
// rtl/store_serializer_if.sv - request and byte-beat memory port bundle
interface store_serializer_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;
    logic [1:0]        req_size;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              done;
    logic              err;

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_data, done, err
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_data, done, err
    );
endinterface

// File: rtl/store_align_check.sv
// rtl/store_align_check.sv - legality check and last-beat index for a store request
module store_align_check
    import store_serializer_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic       illegal,
    output logic [1:0] last_cnt
);

    always_comb begin
        illegal  = 1'b0;
        last_cnt = 2'd0;
        case (size)
            SZ_BYTE: last_cnt = 2'd0;
            SZ_HALF: begin
                last_cnt = 2'd1;
                illegal  = addr_lo[0];
            end
            SZ_WORD: begin
                last_cnt = 2'd3;
                illegal  = |addr_lo;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_serializer.sv
// rtl/store_serializer.sv - narrows a register store into little-endian byte beats
module store_serializer
    import store_serializer_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic clk,
    input  logic rst_n,
    store_serializer_if.slave bus
);

    state_t            state_q, state_d;
    logic [1:0]        cnt_q;
    logic [1:0]        last_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic              err_q;
    logic              illegal;
    logic [1:0]        last_cnt;
    logic              accept;
    logic              beat;

    store_align_check u_align (
        .size     (bus.req_size),
        .addr_lo  (bus.req_addr[1:0]),
        .illegal  (illegal),
        .last_cnt (last_cnt)
    );

    assign accept = (state_q == ST_IDLE) && bus.req_valid;
    assign beat   = (state_q == ST_SEND) && bus.mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            last_q <= 2'd0;
            addr_q <= '0;
            data_q <= 32'd0;
            err_q  <= 1'b0;
        end else if (accept) begin
            cnt_q  <= 2'd0;
            last_q <= last_cnt;
            addr_q <= bus.req_addr;
            data_q <= bus.req_data;
            err_q  <= illegal;
        end else if (beat) begin
            cnt_q <= cnt_q + 2'd1;
        end
    end

    // Beat outputs are decoded from state so reset clears them without waiting for a clock.
    always_comb begin
        state_d       = state_q;
        bus.req_ready = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_data  = 8'd0;
        bus.done      = 1'b0;
        bus.err       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_d = illegal ? ST_RESP : ST_SEND;
                end
            end
            ST_SEND: begin
                bus.mem_valid = 1'b1;
                bus.mem_addr  = addr_q + ADDR_W'(cnt_q);
                bus.mem_data  = data_q[8*cnt_q +: 8];
                if (bus.mem_ready && (cnt_q == last_q)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                bus.done = !err_q;
                bus.err  = err_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_store_serializer.sv
// tb/tb_store_serializer.sv - directed bench for store_serializer
module tb_store_serializer;
    import store_serializer_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    store_serializer_if #(.ADDR_W(32)) bus ();

    store_serializer #(.ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_data  = d;
        bus.req_size  = s;
        step();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] word_b [4];
        logic [7:0] half_b [2];
        logic [31:0] ill_a [3];
        logic [1:0]  ill_s [3];
        word_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        half_b = '{8'h34, 8'h12};
        ill_a  = '{32'h102, 32'h5, 32'h40};
        ill_s  = '{SZ_WORD, SZ_HALF, SZ_ILL};
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'd0;
        bus.req_data  = 32'd0;
        bus.req_size  = SZ_BYTE;
        bus.mem_ready = 1'b1;

        // reset values
        step();
        step();
        chk("rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_data", {24'd0, bus.mem_data}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

        // word store
        issue(32'h100, 32'hA1B2C3D4, SZ_WORD);
        for (int k = 0; k < 4; k++) begin
            chk("word_valid", {31'd0, bus.mem_valid}, 32'd1);
            chk("word_addr", bus.mem_addr, 32'h100 + k);
            chk("word_data", {24'd0, bus.mem_data}, {24'd0, word_b[k]});
            chk("word_ready", {31'd0, bus.req_ready}, 32'd0);
            step();
        end
        chk("word_done", {31'd0, bus.done}, 32'd1);
        chk("word_err", {31'd0, bus.err}, 32'd0);
        chk("word_idle_valid", {31'd0, bus.mem_valid}, 32'd0);
        step();
        chk("word_ready_back", {31'd0, bus.req_ready}, 32'd1);
        chk("word_done_pulse", {31'd0, bus.done}, 32'd0);

        // halfword store
        issue(32'h202, 32'hFFFF1234, SZ_HALF);
        for (int k = 0; k < 2; k++) begin
            chk("half_valid", {31'd0, bus.mem_valid}, 32'd1);
            chk("half_addr", bus.mem_addr, 32'h202 + k);
            chk("half_data", {24'd0, bus.mem_data}, {24'd0, half_b[k]});
            step();
        end
        chk("half_done", {31'd0, bus.done}, 32'd1);
        chk("half_no_extra", {31'd0, bus.mem_valid}, 32'd0);
        step();
        chk("half_ready_back", {31'd0, bus.req_ready}, 32'd1);

        // byte store under backpressure
        bus.mem_ready = 1'b0;
        issue(32'h7, 32'h000000EE, SZ_BYTE);
        for (int k = 0; k < 3; k++) begin
            chk("bp_valid", {31'd0, bus.mem_valid}, 32'd1);
            chk("bp_addr", bus.mem_addr, 32'h7);
            chk("bp_data", {24'd0, bus.mem_data}, 32'hEE);
            chk("bp_done", {31'd0, bus.done}, 32'd0);
            step();
        end
        bus.mem_ready = 1'b1;
        chk("bp_final_valid", {31'd0, bus.mem_valid}, 32'd1);
        chk("bp_final_data", {24'd0, bus.mem_data}, 32'hEE);
        step();
        chk("bp_done_pulse", {31'd0, bus.done}, 32'd1);
        chk("bp_one_beat", {31'd0, bus.mem_valid}, 32'd0);
        step();

        // illegal requests
        for (int k = 0; k < 3; k++) begin
            issue(ill_a[k], 32'h11223344, ill_s[k]);
            chk("ill_err", {31'd0, bus.err}, 32'd1);
            chk("ill_done", {31'd0, bus.done}, 32'd0);
            chk("ill_valid", {31'd0, bus.mem_valid}, 32'd0);
            chk("ill_busy", {31'd0, bus.req_ready}, 32'd0);
            step();
            chk("ill_ready_back", {31'd0, bus.req_ready}, 32'd1);
            chk("ill_err_pulse", {31'd0, bus.err}, 32'd0);
            chk("ill_valid2", {31'd0, bus.mem_valid}, 32'd0);
        end

        // reset after second beat of a word store
        issue(32'h300, 32'h89ABCDEF, SZ_WORD);
        chk("abort_beat0", {24'd0, bus.mem_data}, 32'hEF);
        step();
        chk("abort_beat1", {24'd0, bus.mem_data}, 32'hCD);
        step();
        chk("abort_beat2_present", bus.mem_addr, 32'h302);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", {31'd0, bus.mem_valid}, 32'd0);
        chk("abort_addr", bus.mem_addr, 32'd0);
        chk("abort_data", {24'd0, bus.mem_data}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("post_abort_valid", {31'd0, bus.mem_valid}, 32'd0);
            chk("post_abort_done", {31'd0, bus.done}, 32'd0);
            chk("post_abort_err", {31'd0, bus.err}, 32'd0);
            step();
        end

        // byte store after reset
        issue(32'h7, 32'h12345655, SZ_BYTE);
        chk("after_valid", {31'd0, bus.mem_valid}, 32'd1);
        chk("after_addr", bus.mem_addr, 32'h7);
        chk("after_data", {24'd0, bus.mem_data}, 32'h55);
        step();
        chk("after_done", {31'd0, bus.done}, 32'd1);
        chk("after_err", {31'd0, bus.err}, 32'd0);
        step();
        chk("after_ready", {31'd0, bus.req_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/store_serializer.md
STORE_SERIALIZER -- requirements
Module: store_serializer

Interface
REQ-001 Parameter ADDR_W, default 32: byte-address width of req_addr and mem_addr.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  store request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_addr  input  ADDR_W  byte address of the store.
REQ-007 req_data  input  32  register value; only low bytes used for narrow stores.
REQ-008 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 mem_valid  output  1  byte beat present on the memory port.
REQ-010 mem_ready  input  1  memory accepts the current beat.
REQ-011 mem_addr  output  ADDR_W  byte address of the current beat.
REQ-012 mem_data  output  8  byte data of the current beat.
REQ-013 done  output  1  one-cycle pulse: store completed.
REQ-014 err  output  1  one-cycle pulse: request rejected (misaligned or illegal size).

Function
REQ-015 The block narrows a 32-bit register value to 1, 2 or 4 bytes and serialises them little-endian: byte k = req_data[8k+7:8k] goes to req_addr+k.
REQ-016 FSM states: IDLE, SEND, RESP.
REQ-017 IDLE: req_ready=1, mem_valid=0. A handshake (req_valid && req_ready) latches addr, data and size, then moves to SEND, or to RESP with an error flag when the request is illegal.
REQ-018 Illegal request: req_size=11, halfword with req_addr[0]=1, or word with req_addr[1:0]!=00. An illegal request produces no memory beats.
REQ-019 SEND: mem_valid=1, mem_addr=latched_addr+cnt (mod 2^ADDR_W), mem_data=byte cnt of the latched data, req_ready=0.
REQ-020 A beat completes on mem_valid && mem_ready. On each completed beat cnt increments. The last beat (cnt = 0, 1 or 3 for byte, halfword or word) moves the FSM to RESP.
REQ-021 While mem_valid=1 and mem_ready=0, mem_addr and mem_data are held stable. mem_valid does not drop until the beat is accepted.
REQ-022 RESP lasts exactly one cycle. done=1 if the request was legal, otherwise err=1; done and err are never both high. The FSM then returns to IDLE.
REQ-023 Latency with mem_ready held high: request accepted at edge 0; beats occur in cycles 1..N (N = 1, 2 or 4); done occurs in cycle N+1; req_ready=1 again in cycle N+2.
REQ-024 Latency for an illegal request: err occurs in the cycle after acceptance; req_ready=1 the cycle after that.
REQ-025 Requests presented while req_ready=0 are ignored. The requester holds req_valid and its payload stable until accepted.

Reset
REQ-026 When rst_n is low, the FSM goes to IDLE immediately, regardless of clk.
REQ-027 Reset values: cnt=0, mem_valid=0, mem_addr=0, mem_data=0, done=0, err=0, req_ready=1 after release.
REQ-028 Reset mid-SEND aborts the store. Remaining beats are never issued and no done or err pulse follows.

Structure
REQ-029 A shared package holds the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state type.
REQ-030 One combinational sub-module, store_align_check, computes the illegal flag and the beat count from size and addr[1:0]. All other logic stays in store_serializer.

Verification
REQ-031 Word store: addr=0x100, data=0xA1B2C3D4, size=10, mem_ready=1 -> beats (0x100,D4) (0x101,C3) (0x102,B2) (0x103,A1) in cycles 1-4; done in cycle 5.
REQ-032 Halfword store: addr=0x202, data=0xFFFF1234, size=01 -> beats (0x202,34) (0x203,12) only; then done.
REQ-033 Byte store with backpressure: addr=0x7, data=0x000000EE, size=00, mem_ready low for 3 cycles -> mem_valid=1, mem_addr=0x7 and mem_data=EE stable throughout; one beat completes; then done.
REQ-034 Misaligned/illegal requests: word at 0x102, halfword at 0x5, and size=11 -> no mem_valid in any case; err pulses one cycle after each acceptance; done stays 0.
REQ-035 Reset mid-operation: rst_n pulsed low after the 2nd beat of a word store -> outputs go to zero asynchronously; no further beats, no done; a following byte store completes normally.
